// File: rtl/simon_round_if.sv
// Signal bundle between the Simon round controller and its neighbours:
// the sequence loader, the sequence ROM and the button/LED front end.
interface simon_round_if;
    logic       start;
    logic       seq_reset;
    logic       loader_done;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic       btn_valid;
    logic [1:0] btn_val;
    logic [3:0] led;
    logic [3:0] round;
    logic       win;
    logic       lose;
    logic [3:0] state_dbg;

    modport master (
        input  start, loader_done, rd_data, btn_valid, btn_val,
        output seq_reset, rd_addr, led, round, win, lose, state_dbg
    );

    modport slave (
        output start, loader_done, rd_data, btn_valid, btn_val,
        input  seq_reset, rd_addr, led, round, win, lose, state_dbg
    );
endinterface

// File: rtl/simon_round_ctrl.sv
// Simon game sequencer: reloads the sequence, plays back the current prefix
// on the LEDs, then checks the player's presses until a win or a loss.
module simon_round_ctrl #(
    parameter int N              = 10,
    parameter int ON_CYCLES      = 25000000,
    parameter int OFF_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic          clk,
    input  logic          reset,
    simon_round_if.master bus
);
    localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int MAX_CYC    = (MAX_ON_OFF > TIMEOUT_CYCLES) ? MAX_ON_OFF : TIMEOUT_CYCLES;
    localparam int CW         = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    N_ROUNDS = 4'(N);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD     = 4'd1,
        FETCH    = 4'd2,
        SHOW_ON  = 4'd3,
        SHOW_OFF = 4'd4,
        ARM      = 4'd5,
        INPUT    = 4'd6,
        PAUSE    = 4'd7,
        WIN      = 4'd8,
        LOSE     = 4'd9
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    round_q, round_d;
    logic [3:0]    led_q, led_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;
    logic          seq_reset_q, seq_reset_d;

    function automatic logic [3:0] onehot(input logic [1:0] code);
        case (code)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            default: onehot = 4'b1000;
        endcase
    endfunction

    // Next-state and next-output decode for the round sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_ONE;
        idx_d       = idx_q;
        round_d     = round_q;
        led_d       = led_q;
        win_d       = win_q;
        lose_d      = lose_q;
        seq_reset_d = 1'b0;
        case (state_q)
            IDLE, WIN, LOSE: begin
                cnt_d = CNT_ZERO;
                if (bus.start) begin
                    seq_reset_d = 1'b1;
                    win_d       = 1'b0;
                    lose_d      = 1'b0;
                    round_d     = 4'd0;
                    idx_d       = 4'd0;
                    led_d       = 4'd0;
                    state_d     = LOAD;
                end else begin
                    seq_reset_d = 1'b0;
                end
            end
            LOAD: begin
                // cnt_q==0 marks the first LOAD cycle, where loader_done is still stale
                if (cnt_q == CNT_ZERO) begin
                    cnt_d = CNT_ONE;
                end else if (bus.loader_done) begin
                    round_d = 4'd1;
                    idx_d   = 4'd0;
                    cnt_d   = CNT_ZERO;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            FETCH: begin
                cnt_d   = CNT_ZERO;
                state_d = SHOW_ON;
            end
            SHOW_ON: begin
                // ROM data is valid in the first SHOW_ON cycle; the LED is lit for cnt 1..ON
                if (cnt_q == ON_LAST) begin
                    led_d   = 4'd0;
                    cnt_d   = CNT_ZERO;
                    state_d = SHOW_OFF;
                end else if (cnt_q == CNT_ZERO) begin
                    led_d = onehot(bus.rd_data);
                end else begin
                    led_d = led_q;
                end
            end
            SHOW_OFF: begin
                if (cnt_q == OFF_LAST) begin
                    cnt_d = CNT_ZERO;
                    if ((idx_q + 4'd1) == round_q) begin
                        idx_d   = 4'd0;
                        state_d = ARM;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = SHOW_OFF;
                end
            end
            ARM: begin
                cnt_d   = CNT_ZERO;
                state_d = INPUT;
            end
            INPUT: begin
                led_d = 4'd0;
                if (bus.btn_valid) begin
                    cnt_d = CNT_ZERO;
                    if (bus.btn_val != bus.rd_data) begin
                        lose_d  = 1'b1;
                        state_d = LOSE;
                    end else if ((idx_q + 4'd1) < round_q) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ARM;
                    end else if (round_q == N_ROUNDS) begin
                        win_d   = 1'b1;
                        led_d   = 4'b1111;
                        state_d = WIN;
                    end else begin
                        round_d = round_q + 4'd1;
                        idx_d   = 4'd0;
                        state_d = PAUSE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = CNT_ZERO;
                    lose_d  = 1'b1;
                    state_d = LOSE;
                end else begin
                    state_d = INPUT;
                end
            end
            PAUSE: begin
                if (cnt_q == OFF_LAST) begin
                    cnt_d   = CNT_ZERO;
                    idx_d   = 4'd0;
                    state_d = FETCH;
                end else begin
                    state_d = PAUSE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            idx_q       <= 4'd0;
            round_q     <= 4'd0;
            led_q       <= 4'd0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            seq_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            round_q     <= round_d;
            led_q       <= led_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            seq_reset_q <= seq_reset_d;
        end
    end

    assign bus.seq_reset = seq_reset_q;
    assign bus.rd_addr   = idx_q;
    assign bus.led       = led_q;
    assign bus.round     = round_q;
    assign bus.win       = win_q;
    assign bus.lose      = lose_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: behavioural loader/ROM, directed scenarios and
// randomized games scored against a game-rule reference model.
module tb_simon_round_ctrl;
    localparam int N   = 4;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int TO  = 20;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LOAD  = 4'd1;
    localparam logic [3:0] S_INPUT = 4'd6;

    logic clk = 1'b0;
    logic reset;
    int   errs = 0;
    int   checks = 0;

    logic [1:0] rom [16];
    int         ld_cnt;

    logic [3:0] cap_led [$];
    int         cap_len [$];
    int         cap_gap [$];
    bit         cap_ok;

    simon_round_if bus ();

    simon_round_ctrl #(
        .N(N), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Sequence ROM with one cycle of read latency, and a loader that drops
    // done on seq_reset and raises it again a few cycles later.
    always @(posedge clk) begin
        bus.rd_data <= rom[bus.rd_addr];
        if (reset) begin
            bus.loader_done <= 1'b1;
            ld_cnt          <= 0;
        end else if (bus.seq_reset) begin
            bus.loader_done <= 1'b0;
            ld_cnt          <= 3;
        end else if (ld_cnt == 1) begin
            bus.loader_done <= 1'b1;
            ld_cnt          <= 0;
        end else if (ld_cnt > 1) begin
            ld_cnt <= ld_cnt - 1;
        end
    end

    function automatic logic [3:0] onehot_ref(input logic [1:0] c);
        logic [3:0] one;
        one = 4'd1;
        return one << c;
    endfunction

    // Discrepancies between the captured playback and what round r must show.
    function automatic int pb_errors(input int r);
        int e = 0;
        if (cap_led.size() != r) e++;
        for (int k = 0; k < cap_led.size() && k < r; k++)
            if (cap_led[k] !== onehot_ref(rom[k]) || cap_len[k] != ON) e++;
        foreach (cap_gap[k]) if (cap_gap[k] < OFF) e++;
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic press(input logic [1:0] code);
        bus.btn_valid = 1'b1;
        bus.btn_val   = code;
        tick();
        bus.btn_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.state_dbg == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Record lit LED runs until the input phase, spraying random presses meanwhile.
    task automatic capture();
        logic [3:0] prev;
        int         run;
        cap_led.delete(); cap_len.delete(); cap_gap.delete();
        cap_ok = 1'b0;
        prev   = 4'h0;
        run    = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.state_dbg == S_INPUT) begin
                cap_ok = 1'b1;
                break;
            end
            if (bus.led == prev) run++;
            else begin
                if (prev != 4'h0) begin
                    cap_led.push_back(prev);
                    cap_len.push_back(run);
                end else if (cap_led.size() > 0) begin
                    cap_gap.push_back(run);
                end
                prev = bus.led;
                run  = 1;
            end
            bus.btn_valid = 1'($urandom_range(0, 1));
            bus.btn_val   = 2'($urandom_range(0, 3));
            tick();
        end
        bus.btn_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            obs = {bus.led, bus.round, bus.win, bus.lose, bus.seq_reset, bus.state_dbg};
            checks++;
            if (obs !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE}) begin
                errs++;
                $display("FAIL reset_idle cyc%0d: got %h want %h", i, obs, {11'd0, S_IDLE});
            end
            bus.btn_valid = 1'($urandom_range(0, 1));
            bus.btn_val   = 2'($urandom_range(0, 3));
            tick();
        end
        bus.btn_valid = 1'b0;
    endtask

    task automatic test_start();
        int hi;
        drive_start();
        checks++;
        if (bus.seq_reset !== 1'b1) begin
            errs++; $display("FAIL seq_reset_rise: got %b want 1", bus.seq_reset);
        end
        tick();
        checks++;
        if ({bus.state_dbg, bus.round} !== {S_LOAD, 4'd0}) begin
            errs++; $display("FAIL stale_done: got state %0d round %0d want %0d 0", bus.state_dbg, bus.round, S_LOAD);
        end
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.seq_reset) hi++;
            tick();
        end
        checks++;
        if (hi !== 0) begin
            errs++; $display("FAIL seq_reset_len: got %0d extra cycles want 0", hi);
        end
        capture();
        checks++;
        if ({cap_ok, bus.round} !== {1'b1, 4'd1}) begin
            errs++; $display("FAIL first_round: got ok %b round %0d want 1 1", cap_ok, bus.round);
        end
        checks++;
        if (pb_errors(1) !== 0) begin
            errs++; $display("FAIL playback_r1: got %0d runs, %0d bad want 1 run", cap_led.size(), pb_errors(1));
        end
    endtask

    task automatic test_perfect();
        bit ok;
        drive_start();
        checks++;
        if ({bus.seq_reset, bus.state_dbg, bus.round} !== {1'b0, S_INPUT, 4'd1}) begin
            errs++; $display("FAIL start_in_input: got %b %0d %0d want 0 %0d 1", bus.seq_reset, bus.state_dbg, bus.round, S_INPUT);
        end
        for (int r = 1; r <= N; r++) begin
            if (r > 1) begin
                capture();
                checks++;
                if ({cap_ok, bus.round} !== {1'b1, 4'(r)}) begin
                    errs++; $display("FAIL perfect_round: got ok %b round %0d want 1 %0d", cap_ok, bus.round, r);
                end
                checks++;
                if (pb_errors(r) !== 0) begin
                    errs++; $display("FAIL playback_r%0d: got %0d runs, %0d bad want %0d runs", r, cap_led.size(), pb_errors(r), r);
                end
            end
            for (int i = 0; i < r; i++) begin
                if (i > 0) begin
                    wait_state(S_INPUT, 50, ok);
                    checks++;
                    if (ok !== 1'b1) begin
                        errs++; $display("FAIL rearm_r%0d_i%0d: got no INPUT want INPUT", r, i);
                    end
                end
                press(rom[i]);
            end
        end
        checks++;
        if ({bus.win, bus.lose, bus.led, bus.round} !== {1'b1, 1'b0, 4'hF, 4'd4}) begin
            errs++; $display("FAIL win: got win %b lose %b led %b round %0d want 1 0 1111 4", bus.win, bus.lose, bus.led, bus.round);
        end
        repeat (3) tick();
        checks++;
        if ({bus.win, bus.led, bus.round} !== {1'b1, 4'hF, 4'd4}) begin
            errs++; $display("FAIL win_hold: got win %b led %b round %0d want 1 1111 4", bus.win, bus.led, bus.round);
        end
    endtask

    task automatic test_mismatch();
        bit ok;
        drive_start();
        checks++;
        if ({bus.seq_reset, bus.win, bus.round} !== {1'b1, 1'b0, 4'd0}) begin
            errs++; $display("FAIL restart_from_win: got %b %b %0d want 1 0 0", bus.seq_reset, bus.win, bus.round);
        end
        capture();
        press(rom[0]);
        capture();
        checks++;
        if ({cap_ok, bus.round} !== {1'b1, 4'd2}) begin
            errs++; $display("FAIL mm_round2: got ok %b round %0d want 1 2", cap_ok, bus.round);
        end
        press(rom[0]);
        wait_state(S_INPUT, 50, ok);
        press(rom[1] ^ 2'd1);
        checks++;
        if ({bus.lose, bus.win, bus.round, bus.led} !== {1'b1, 1'b0, 4'd2, 4'd0}) begin
            errs++; $display("FAIL wrong_press: got lose %b win %b round %0d led %b want 1 0 2 0000", bus.lose, bus.win, bus.round, bus.led);
        end
        repeat (3) tick();
        checks++;
        if ({bus.lose, bus.round} !== {1'b1, 4'd2}) begin
            errs++; $display("FAIL lose_hold: got lose %b round %0d want 1 2", bus.lose, bus.round);
        end
        drive_start();
        checks++;
        if ({bus.seq_reset, bus.lose, bus.round} !== {1'b1, 1'b0, 4'd0}) begin
            errs++; $display("FAIL restart_from_lose: got %b %b %0d want 1 0 0", bus.seq_reset, bus.lose, bus.round);
        end
        capture();
        checks++;
        if ({cap_ok, bus.round} !== {1'b1, 4'd1}) begin
            errs++; $display("FAIL restart_round1: got ok %b round %0d want 1 1", cap_ok, bus.round);
        end
    endtask

    task automatic test_timeout();
        int n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.state_dbg == S_INPUT) n++;
            else break;
        end
        checks++;
        if (n !== TO) begin
            errs++; $display("FAIL timeout_len: got %0d input cycles want %0d", n, TO);
        end
        checks++;
        if ({bus.lose, bus.round} !== {1'b1, 4'd1}) begin
            errs++; $display("FAIL timeout_lose: got lose %b round %0d want 1 1", bus.lose, bus.round);
        end
        drive_start();
        capture();
        repeat (TO - 1) tick();
        checks++;
        if (bus.state_dbg !== S_INPUT) begin
            errs++; $display("FAIL timeout_early: got state %0d want %0d", bus.state_dbg, S_INPUT);
        end
        press(rom[0]);
        checks++;
        if ({bus.lose, bus.round} !== {1'b0, 4'd2}) begin
            errs++; $display("FAIL press_at_expiry: got lose %b round %0d want 0 2", bus.lose, bus.round);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found = 1'b0;
        logic [20:0] obs;
        capture();
        press(rom[0]);
        wait_state(S_INPUT, 50, ok);
        press(rom[1]);
        for (int i = 0; i < 100; i++) begin
            if (bus.round == 4'd3 && bus.led == onehot_ref(rom[1])) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (found !== 1'b1) begin
            errs++; $display("FAIL reach_r3_show: got not found want found");
        end
        reset = 1'b1;
        tick();
        obs = {bus.led, bus.round, bus.win, bus.lose, bus.seq_reset, bus.rd_addr, bus.state_dbg};
        checks++;
        if (obs !== {17'd0, S_IDLE}) begin
            errs++; $display("FAIL reset_mid: got %h want %h", obs, {17'd0, S_IDLE});
        end
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.state_dbg, bus.round} !== {S_IDLE, 4'd0}) begin
            errs++; $display("FAIL reset_stay_idle: got %0d %0d want %0d 0", bus.state_dbg, bus.round, S_IDLE);
        end
    endtask

    // Random ROM, random fault point; outcome predicted from the game rules.
    task automatic test_random();
        bit         ok, done, exp_win;
        int         fail_r, fail_i, kind;
        logic [1:0] wrong;
        logic [3:0] exp_round;
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < N; i++) rom[i] = 2'($urandom_range(0, 3));
            fail_r = $urandom_range(1, N + 1);
            fail_i = (fail_r <= N) ? $urandom_range(0, fail_r - 1) : 0;
            kind   = $urandom_range(0, 1);
            done   = 1'b0;
            drive_start();
            for (int r = 1; r <= N && !done; r++) begin
                capture();
                checks++;
                if ({cap_ok, bus.round} !== {1'b1, 4'(r)} || pb_errors(r) !== 0) begin
                    errs++; $display("FAIL rnd_g%0d_r%0d: got ok %b round %0d runs %0d bad %0d want round %0d", g, r, cap_ok, bus.round, cap_led.size(), pb_errors(r), r);
                end
                for (int i = 0; i < r && !done; i++) begin
                    if (i > 0) wait_state(S_INPUT, 50, ok);
                    if (r == fail_r && i == fail_i) begin
                        if (kind == 0) begin
                            wrong = rom[i] ^ 2'($urandom_range(1, 3));
                            press(wrong);
                        end else begin
                            for (int k = 0; k < TO + 5; k++) begin
                                if (bus.state_dbg != S_INPUT) break;
                                tick();
                            end
                        end
                        done = 1'b1;
                    end else begin
                        repeat ($urandom_range(0, 5)) tick();
                        press(rom[i]);
                    end
                end
            end
            exp_win   = (fail_r == N + 1);
            exp_round = exp_win ? 4'(N) : 4'(fail_r);
            checks++;
            if ({bus.win, bus.lose, bus.round, bus.led} !== {exp_win, ~exp_win, exp_round, exp_win ? 4'hF : 4'h0}) begin
                errs++; $display("FAIL rnd_outcome_g%0d: got win %b lose %b round %0d led %b want %b %b %0d", g, bus.win, bus.lose, bus.round, bus.led, exp_win, ~exp_win, exp_round);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 2'd0;
        rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd3; rom[3] = 2'd1;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.btn_valid = 1'b0;
        bus.btn_val   = 2'd0;
        tick();
        test_reset();
        test_start();
        test_perfect();
        test_mismatch();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
Top-level game sequencer for the Simon datapath. It restarts the sequence loader, replays the stored sequence prefix on the LEDs for the current round, then checks player presses against the sequence ROM. It extends the round until N steps are matched (win) or a mismatch or timeout occurs (lose). It sits between sequence_loader/seq ROM and the button/LED front end.

Parameters:
N, 10, sequence length and number of rounds to win (1..15).
ON_CYCLES, 25000000, clocks each LED is lit during playback.
OFF_CYCLES, 12500000, clocks dark between playback steps, and the pause before a new round.
TIMEOUT_CYCLES, 250000000, maximum clocks allowed between presses in input phase.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous active-high reset.
start  in  1  single-cycle pulse; begins a new game.
seq_reset  out  1  registered one-cycle pulse that resets sequence_loader (reloads the ROM).
loader_done  in  1  sequence_loader done flag.
rd_addr  out  4  seq ROM read address; always equals the internal step index.
rd_data  in  2  seq ROM data; reflects rd_addr of the previous cycle (1-cycle latency).
btn_valid  in  1  single-cycle debounced press strobe.
btn_val  in  2  pressed button code, valid with btn_valid.
led  out  4  one-hot LED drive (bit k lit for code k).
round  out  4  current round length (0 when not playing).
win  out  1  high while in WIN.
lose  out  1  high while in LOSE.
state_dbg  out  4  current FSM state encoding.

Behaviour:
- All outputs are registered. Synchronous reset forces: state IDLE, step idx=0, rd_addr=0, led=0, round=0, win=0, lose=0, seq_reset=0, all counters 0. Reset mid-game aborts immediately to IDLE.
- States: IDLE, LOAD, FETCH, SHOW_ON, SHOW_OFF, ARM, INPUT, PAUSE, WIN, LOSE.
- IDLE/WIN/LOSE + start: seq_reset=1 for exactly one cycle, win=lose=0, round=0, go LOAD. start is ignored in every other state.
- LOAD: loader_done is ignored in the first LOAD cycle (stale flag). Afterwards, loader_done=1 sets round=1 and idx=0, then goes FETCH.
- FETCH: 1 cycle; rd_addr=idx is already stable. Next state is SHOW_ON.
- SHOW_ON: on entry, led<=onehot(rd_data). It holds for exactly ON_CYCLES cycles, then goes SHOW_OFF with led=0.
- SHOW_OFF: holds OFF_CYCLES cycles.
  - If idx+1==round: idx=0, go ARM.
  - Otherwise: idx+1, go FETCH.
- ARM: 1 cycle, allowing rd_data to settle for the new idx. It clears the timeout counter, then goes INPUT. btn_valid in ARM is ignored (dropped).
- INPUT: led=0; the timeout counter increments each cycle.
  - btn_valid with btn_val==rd_data (correct):
    - If idx+1<round: idx+1, go ARM.
    - Else if round==N: go WIN.
    - Else: round+1, idx=0, go PAUSE.
  - btn_valid with btn_val!=rd_data: go LOSE.
  - No press while counter reaches TIMEOUT_CYCLES-1: go LOSE.
  - A press in the same cycle as timeout expiry takes priority over the timeout.
- PAUSE: led=0 for OFF_CYCLES cycles, then go FETCH (idx=0).
- WIN: win=1, led=4'b1111, round holds N. LOSE: lose=1, led=0, round holds the failed round. Both persist until start or reset.
- Counters are wide enough for max(ON,OFF,TIMEOUT) (28 bits at defaults). idx and round are 4 bits and never exceed N.
- btn_valid outside INPUT has no effect.

Test Plan:
(All benches: N=4, ON_CYCLES=3, OFF_CYCLES=2, TIMEOUT_CYCLES=20; behavioural loader and ROM preloaded with 2,0,3,1.)
1. Reset then idle 10 cycles -> led=0, round=0, win=lose=0, seq_reset=0, state_dbg=IDLE throughout.
2. start pulse -> seq_reset high exactly one cycle. After loader_done, round=1; led=4'b0100 for exactly 3 cycles, then 0 for 2 cycles, then state INPUT.
3. Perfect play, pressing the correct codes each round -> playback lengths 1,2,3,4 with led sequence 0100,0001,1000,0010. After the 4th round's last press: win=1, led=1111, round=4.
4. Round 2, second press btn_val=1 (expected 0) -> next cycle lose=1, round=2, led=0. A second start from LOSE -> seq_reset pulse and round restarts at 1.
5. In INPUT, no press for 20 cycles -> lose=1 exactly at cycle 20. A correct press on cycle 20 instead -> progress continues and no lose.
6. Assert reset during SHOW_ON of round 3 -> next cycle all outputs at reset values. A btn_valid during SHOW_ON/ARM/PAUSE -> no state, round or idx change.
